// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the data-memory initiator: op codes, mux selects, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

    localparam int unsigned MEM_DEPTH_DEF   = 256;
    localparam int unsigned STACK_TOP_DEF   = 255;
    localparam int unsigned STACK_LIMIT_DEF = 192;

    // Request op encodings; 5-7 are illegal and rejected at accept.
    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_STORE   = 3'd1;
    localparam logic [2:0] OP_PUSH_RF = 3'd2;
    localparam logic [2:0] OP_PUSH_PC = 3'd3;
    localparam logic [2:0] OP_POP     = 3'd4;

    // dataMemory address-source select (stack_mem).
    localparam logic MEM_STORE    = 1'b0;
    localparam logic STACK_STORE  = 1'b1;
    // dataMemory write-data source select (address_data).
    localparam logic ADDR_DATA_RF = 1'b0;
    localparam logic ADDR_DATA_PC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_POP);
    endfunction

    function automatic logic op_is_push(input logic [2:0] op);
        return (op == OP_PUSH_RF) || (op == OP_PUSH_PC);
    endfunction

    // Address source the access must finally present to dataMemory.
    function automatic logic tgt_stack_sel(input logic [2:0] op);
        return (op_is_push(op) || (op == OP_POP)) ? STACK_STORE : MEM_STORE;
    endfunction

    // Write-data source the access must finally present to dataMemory.
    function automatic logic tgt_data_sel(input logic [2:0] op);
        return (op == OP_PUSH_PC) ? ADDR_DATA_PC : ADDR_DATA_RF;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store/push/pop initiator for dataMemory; owns the stack pointer.
// Latency: response 4 cycles after accept for writes, 5 for reads, 1 for rejected requests.
// Backpressure: req_ready only in IDLE (requests while busy are dropped); no response backpressure.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int unsigned STACK_TOP   = STACK_TOP_DEF,
    parameter int unsigned STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] sp_out,
    output logic        mem_EN,
    output logic        mem_ENR,
    output logic        mem_ENW,
    output logic        mem_stack_mem,
    output logic        mem_address_data,
    output logic [31:0] mem_ALUaddress,
    output logic [31:0] mem_stackPointer,
    output logic [31:0] mem_regData,
    output logic [31:0] mem_addData,
    input  logic [31:0] mem_dataOut
);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] sp_d;
    logic        ready_d, en_d, enr_d, enw_d, sm_d, ad_d, rv_d, err_d;
    logic [31:0] alu_d, spb_d, reg_d, add_d, rdata_d;
    logic        acc_err;

    // Reject check on the request currently offered, using the live stack pointer.
    always_comb begin
        acc_err = 1'b0;
        case (req_op)
            OP_LOAD, OP_STORE:     acc_err = (req_addr >= 32'(MEM_DEPTH));
            OP_PUSH_RF, OP_PUSH_PC: acc_err = (sp_out < 32'(STACK_LIMIT));
            OP_POP:                acc_err = (sp_out == 32'(STACK_TOP));
            default:               acc_err = 1'b1;
        endcase
    end

    // Next state plus next value of every registered output. The selects are driven
    // to their complement in PRIME so dataMemory sees a change when SETUP restores them.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sp_d    = sp_out;
        en_d    = 1'b0;
        enr_d   = 1'b0;
        enw_d   = 1'b0;
        sm_d    = mem_stack_mem;
        ad_d    = mem_address_data;
        alu_d   = mem_ALUaddress;
        spb_d   = mem_stackPointer;
        reg_d   = mem_regData;
        add_d   = mem_addData;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        rdata_d = resp_rdata;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d = req_op;
                    if (acc_err) begin
                        state_d = ST_RESP;
                        rv_d    = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_PRIME;
                        en_d    = 1'b1;
                        sm_d    = ~tgt_stack_sel(req_op);
                        ad_d    = ~tgt_data_sel(req_op);
                        alu_d   = req_addr;
                        spb_d   = (req_op == OP_POP) ? sp_out + 32'd1 : sp_out;
                        reg_d   = req_wdata;
                        add_d   = req_pc;
                    end
                end
            end
            ST_PRIME: begin
                state_d = ST_SETUP;
                en_d    = 1'b1;
                sm_d    = tgt_stack_sel(op_q);
                ad_d    = tgt_data_sel(op_q);
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                en_d    = 1'b1;
                enr_d   = op_is_read(op_q);
                enw_d   = ~op_is_read(op_q);
            end
            ST_ACCESS: begin
                if (op_is_push(op_q)) begin
                    sp_d = sp_out - 32'd1;
                end else if (op_q == OP_POP) begin
                    sp_d = sp_out + 32'd1;
                end
                if (op_is_read(op_q)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RESP;
                    rv_d    = 1'b1;
                end
            end
            ST_WAIT: begin
                state_d = ST_RESP;
                rv_d    = 1'b1;
                rdata_d = mem_dataOut;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State, stack pointer and all outputs registered together; reset aborts any access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            op_q             <= OP_LOAD;
            sp_out           <= 32'(STACK_TOP);
            req_ready        <= 1'b1;
            mem_EN           <= 1'b0;
            mem_ENR          <= 1'b0;
            mem_ENW          <= 1'b0;
            mem_stack_mem    <= MEM_STORE;
            mem_address_data <= ADDR_DATA_RF;
            mem_ALUaddress   <= '0;
            mem_stackPointer <= '0;
            mem_regData      <= '0;
            mem_addData      <= '0;
            resp_valid       <= 1'b0;
            resp_err         <= 1'b0;
            resp_rdata       <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            sp_out           <= sp_d;
            req_ready        <= ready_d;
            mem_EN           <= en_d;
            mem_ENR          <= enr_d;
            mem_ENW          <= enw_d;
            mem_stack_mem    <= sm_d;
            mem_address_data <= ad_d;
            mem_ALUaddress   <= alu_d;
            mem_stackPointer <= spb_d;
            mem_regData      <= reg_d;
            mem_addData      <= add_d;
            resp_valid       <= rv_d;
            resp_err         <= err_d;
            resp_rdata       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural dataMemory alongside.
// Latency: measured in cycles from the accept edge (first cycle after accept = 1).
// Backpressure: requests are only offered once req_ready is seen high.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, sp_out;
    logic        mem_EN, mem_ENR, mem_ENW, mem_stack_mem, mem_address_data;
    logic [31:0] mem_ALUaddress, mem_stackPointer, mem_regData, mem_addData;
    logic [31:0] mem_dataOut = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int both_hi  = 0;

    always #5 clock = ~clock;

    mem_access_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sp_out(sp_out), .mem_EN(mem_EN), .mem_ENR(mem_ENR), .mem_ENW(mem_ENW),
        .mem_stack_mem(mem_stack_mem), .mem_address_data(mem_address_data),
        .mem_ALUaddress(mem_ALUaddress), .mem_stackPointer(mem_stackPointer),
        .mem_regData(mem_regData), .mem_addData(mem_addData), .mem_dataOut(mem_dataOut)
    );

    // dataMemory model: address/data muxes resample only when their select changes.
    logic [31:0] mem [256];
    logic        mem_loaded = 1'b0;
    logic        sm_prev = 1'b0, ad_prev = 1'b0;
    logic [31:0] lat_addr = 32'd0, lat_data = 32'd0;
    logic [31:0] a_eff, d_eff;

    always_comb begin
        a_eff = lat_addr;
        d_eff = lat_data;
        if (mem_stack_mem != sm_prev) a_eff = mem_stack_mem ? mem_stackPointer : mem_ALUaddress;
        if (mem_address_data != ad_prev) d_eff = mem_address_data ? mem_addData : mem_regData;
    end

    always @(posedge clock) begin
        sm_prev  <= mem_stack_mem;
        ad_prev  <= mem_address_data;
        lat_addr <= a_eff;
        lat_data <= d_eff;
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[0]     <= 32'd10;
            mem[60]    <= 32'd5;
            mem_loaded <= 1'b1;
        end else begin
            if (mem_EN && mem_ENW) mem[a_eff[7:0]] <= d_eff;
            if (mem_EN && mem_ENR) mem_dataOut <= mem[a_eff[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one request once ready, then count cycles until the response pulse.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, output int lat, output logic [31:0] rdata,
                          output logic err, output int strobes,
                          output logic sm1, output logic sm2, output logic ad1, output logic ad2);
        lat = 99; rdata = 32'hx; err = 1'bx; strobes = 0;
        sm1 = 1'bx; sm2 = 1'bx; ad1 = 1'bx; ad2 = 1'bx;
        for (int w = 0; w < 20; w++) begin
            if (req_ready) break;
            @(negedge clock);
        end
        req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (mem_ENR || mem_ENW) strobes++;
            if (mem_ENR && mem_ENW) both_hi++;
            if (n == 1) begin sm1 = mem_stack_mem; ad1 = mem_address_data; end
            if (n == 2) begin sm2 = mem_stack_mem; ad2 = mem_address_data; end
            if (resp_valid) begin
                lat = n; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    initial begin
        int          lat, strobes, errs;
        logic [31:0] rd;
        logic        er, sm1, sm2, ad1, ad2;

        reset = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        req_addr = '0; req_wdata = '0; req_pc = '0;
        repeat (3) @(negedge clock);
        check("rst_sp", sp_out, 32'd255);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_strobes", {29'd0, mem_EN, mem_ENR, mem_ENW}, 32'd0);
        check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rel_sp", sp_out, 32'd255);
        check("rel_ready", {31'd0, req_ready}, 32'd1);

        // LOAD from preloaded word 0.
        do_req(OP_LOAD, 32'd0, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("load0_lat", lat, 32'd5);
        check("load0_rdata", rd, 32'd10);
        check("load0_err", {31'd0, er}, 32'd0);
        check("load0_sel_prime", {30'd0, sm1, ad1}, 32'd3);
        check("load0_sel_setup", {30'd0, sm2, ad2}, 32'd0);
        check("load0_strobes", strobes, 32'd1);

        // STORE then read back.
        do_req(OP_STORE, 32'd40, 32'hDEADBEEF, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("store40_lat", lat, 32'd4);
        check("store40_err", {31'd0, er}, 32'd0);
        do_req(OP_LOAD, 32'd40, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("load40_rdata", rd, 32'hDEADBEEF);

        // Stack round trip.
        do_req(OP_PUSH_PC, 32'd0, 32'd0, 32'h1234, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("pushpc_lat", lat, 32'd4);
        check("pushpc_sel_setup", {30'd0, sm2, ad2}, 32'd3);
        check("pushpc_sp", sp_out, 32'd254);
        do_req(OP_PUSH_RF, 32'd0, 32'h55, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("pushrf_sp", sp_out, 32'd253);
        do_req(OP_POP, 32'd0, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("pop1_lat", lat, 32'd5);
        check("pop1_rdata", rd, 32'h55);
        check("pop1_sp", sp_out, 32'd254);
        do_req(OP_POP, 32'd0, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("pop2_rdata", rd, 32'h1234);
        check("pop2_sp", sp_out, 32'd255);

        // Underflow on empty stack.
        do_req(OP_POP, 32'd0, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("underflow_lat", lat, 32'd1);
        check("underflow_err", {31'd0, er}, 32'd1);
        check("underflow_strobes", strobes, 32'd0);
        check("underflow_rdata_held", rd, 32'h1234);
        check("underflow_sp", sp_out, 32'd255);

        // Fill the stack down to the limit, then overflow.
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            do_req(OP_PUSH_RF, 32'd0, 32'(i), 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
            if (er !== 1'b0) errs++;
        end
        check("fill_errs", errs, 32'd0);
        check("fill_sp", sp_out, 32'd191);
        do_req(OP_PUSH_RF, 32'd0, 32'hAA, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("overflow_err", {31'd0, er}, 32'd1);
        check("overflow_lat", lat, 32'd1);
        check("overflow_sp", sp_out, 32'd191);

        do_req(OP_LOAD, 32'd256, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("addr256_err", {31'd0, er}, 32'd1);
        check("addr256_strobes", strobes, 32'd0);
        do_req(3'd6, 32'd0, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("op6_err", {31'd0, er}, 32'd1);

        // Reset during SETUP of a STORE must abort the write.
        for (int w = 0; w < 20; w++) begin
            if (req_ready) break;
            @(negedge clock);
        end
        req_op = OP_STORE; req_addr = 32'd60; req_wdata = 32'd7; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort_setup_en", {31'd0, mem_EN}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_strobes", {29'd0, mem_EN, mem_ENR, mem_ENW}, 32'd0);
        check("abort_sp", sp_out, 32'd255);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_sel", {30'd0, mem_stack_mem, mem_address_data}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_req(OP_LOAD, 32'd60, 32'd0, 32'd0, lat, rd, er, strobes, sm1, sm2, ad1, ad2);
        check("load60_rdata", rd, 32'd5);
        check("load60_err", {31'd0, er}, 32'd0);

        check("never_both_strobes", both_hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
